// File: rtl/uart_rx_frame_ctrl.sv
// Framed byte receiver: SYNC, LEN, LEN payload bytes and an XOR checksum byte.
// A verified payload is held in a small buffer until the consumer drains it.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 8,
    parameter int         TIMEOUT   = 32
) (
    input  logic       CLK_BPS,
    input  logic       reset,
    input  logic       accept,
    input  logic [7:0] receive_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       frame_ready,
    output logic [3:0] frame_len,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int PTR_W = $clog2(MAX_LEN + 1);
    localparam int DEPTH = 1 << PTR_W;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_LEN = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        HOLD    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   len_q, len_d;
    logic [7:0]         chk_q, chk_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];
    logic               frame_ready_q, frame_ready_d;
    logic               frame_error_q, frame_error_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;
    logic               in_frame;
    logic               timeout_hit;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        len_d         = len_q;
        chk_d         = chk_q;
        mem_d         = mem_q;
        overrun_d     = overrun_q;
        frame_error_d = 1'b0;

        in_frame = (state_q == GET_LEN) || (state_q == PAYLOAD) || (state_q == CHECK);
        // An accept arriving on the terminal count wins over the timeout.
        timeout_hit = in_frame && !accept && (tmo_q == TMO_W'(TIMEOUT - 1));
        tmo_d = accept ? '0 : tmo_q + TMO_W'(1);

        case (state_q)
            IDLE: begin
                if (accept && receive_data == SYNC_BYTE) begin
                    state_d = GET_LEN;
                end
            end
            GET_LEN: begin
                if (accept) begin
                    if (receive_data != 8'd0 && receive_data <= 8'(MAX_LEN)) begin
                        len_d   = PTR_W'(receive_data);
                        chk_d   = receive_data;
                        state_d = PAYLOAD;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    mem_d[wr_ptr_q] = receive_data;
                    wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                    chk_d           = chk_q ^ receive_data;
                    if (wr_ptr_q == len_q - PTR_W'(1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (receive_data == chk_q) begin
                        state_d = HOLD;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    overrun_d = 1'b1;
                end
                if (rd_en) begin
                    if (rd_ptr_q == len_q - PTR_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout_hit) begin
            frame_error_d = 1'b1;
            state_d       = IDLE;
        end

        // Frame bookkeeping is wiped whenever the block returns to (or sits in) IDLE.
        if (state_d == IDLE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            len_d    = '0;
            chk_d    = '0;
        end

        if (state_d == IDLE || state_d == HOLD) begin
            tmo_d = '0;
        end

        frame_ready_d = (state_d == HOLD);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge CLK_BPS) begin
        mem_q <= mem_d;
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            len_q         <= '0;
            chk_q         <= '0;
            tmo_q         <= '0;
            frame_ready_q <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            len_q         <= len_d;
            chk_q         <= chk_d;
            tmo_q         <= tmo_d;
            frame_ready_q <= frame_ready_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign rd_data     = (!reset && state_q == HOLD) ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_ready = frame_ready_q;
    assign frame_len   = 4'(len_q);
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: a vector table for the main frame
// scenarios plus hand-written timeout and full-length sequences.
module tb_uart_rx_frame_ctrl;

    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       accept = 1'b0;
    logic [7:0] receive_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       frame_ready;
    logic [3:0] frame_len;
    logic       frame_error;
    logic       overrun;
    logic       busy;
    logic [2:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_frame_ctrl #(
        .SYNC_BYTE(8'hA5),
        .MAX_LEN  (8),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK_BPS     (clk),
        .reset       (reset),
        .accept      (accept),
        .receive_data(receive_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_len   (frame_len),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       acc;
        logic [7:0] data;
        logic       rd;
        logic       rdy;
        logic       err;
        logic       bsy;
        logic       ovr;
        logic       chk;   // compare frame_len and rd_data on this row
        logic [3:0] len;
        logic [7:0] rdd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic acc, input logic [7:0] data, input logic rd,
                       input logic rdy, input logic err, input logic bsy, input logic ovr,
                       input logic chk, input logic [3:0] len, input logic [7:0] rdd);
        vec_t v;
        v.rst = rst; v.acc = acc; v.data = data; v.rd = rd;
        v.rdy = rdy; v.err = err; v.bsy = bsy; v.ovr = ovr;
        v.chk = chk; v.len = len; v.rdd = rdd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, settle just after the rising edge.
    task automatic step(input logic r, input logic a, input logic [7:0] d, input logic rd);
        @(negedge clk);
        reset = r; accept = a; receive_data = d; rd_en = rd;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        int errs;

        // reset state
        add(1, 0, 8'h00, 0,  0, 0, 0, 0,  1, 4'd0, 8'h00);
        add(0, 0, 8'h00, 0,  0, 0, 0, 0,  0, 4'd0, 8'h00);
        // good 3-byte frame, drained
        add(0, 1, 8'hA5, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h03, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h11, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h22, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h33, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h03, 0,  1, 0, 1, 0,  1, 4'd3, 8'h11);
        add(0, 0, 8'h00, 1,  1, 0, 1, 0,  1, 4'd3, 8'h22);
        add(0, 0, 8'h00, 1,  1, 0, 1, 0,  1, 4'd3, 8'h33);
        add(0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 4'd0, 8'h00);
        add(0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 4'd0, 8'h00);
        // bad checksum (00 instead of 32)
        add(0, 1, 8'hA5, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h02, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h10, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h20, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h00, 0,  0, 1, 0, 0,  0, 4'd0, 8'h00);
        add(0, 0, 8'h00, 0,  0, 0, 0, 0,  0, 4'd0, 8'h00);
        // zero and oversize lengths, SYNC taken right after each error
        add(0, 1, 8'hA5, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h00, 0,  0, 1, 0, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'hA5, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h09, 0,  0, 1, 0, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'hA5, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h01, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'hFF, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'hFE, 0,  1, 0, 1, 0,  1, 4'd1, 8'hFF);
        add(0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 4'd0, 8'h00);
        // overrun while holding: checksum 02^AA^BB = 13
        add(0, 1, 8'hA5, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h02, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'hAA, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'hBB, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h13, 0,  1, 0, 1, 0,  1, 4'd2, 8'hAA);
        add(0, 1, 8'h55, 0,  1, 0, 1, 1,  1, 4'd2, 8'hAA);
        add(0, 0, 8'h00, 0,  1, 0, 1, 1,  1, 4'd2, 8'hAA);
        add(0, 0, 8'h00, 1,  1, 0, 1, 1,  1, 4'd2, 8'hBB);
        add(0, 0, 8'h00, 1,  0, 0, 0, 1,  0, 4'd0, 8'h00);
        add(0, 0, 8'h00, 0,  0, 0, 0, 1,  0, 4'd0, 8'h00);
        // reset mid-frame, then a 1-byte frame
        add(0, 1, 8'hA5, 0,  0, 0, 1, 1,  0, 4'd0, 8'h00);
        add(0, 1, 8'h03, 0,  0, 0, 1, 1,  0, 4'd0, 8'h00);
        add(0, 1, 8'h11, 0,  0, 0, 1, 1,  0, 4'd0, 8'h00);
        add(1, 0, 8'h00, 0,  0, 0, 0, 0,  1, 4'd0, 8'h00);
        add(1, 1, 8'hA5, 1,  0, 0, 0, 0,  1, 4'd0, 8'h00);
        add(0, 1, 8'hA5, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'h01, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'hFF, 0,  0, 0, 1, 0,  0, 4'd0, 8'h00);
        add(0, 1, 8'hFE, 0,  1, 0, 1, 0,  1, 4'd1, 8'hFF);
        add(0, 0, 8'h00, 1,  0, 0, 0, 0,  0, 4'd0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].acc, vecs[i].data, vecs[i].rd);
            check("frame_ready", i, 32'(frame_ready), 32'(vecs[i].rdy));
            check("frame_error", i, 32'(frame_error), 32'(vecs[i].err));
            check("busy", i, 32'(busy), 32'(vecs[i].bsy));
            check("overrun", i, 32'(overrun), 32'(vecs[i].ovr));
            if (vecs[i].chk) begin
                check("frame_len", i, 32'(frame_len), 32'(vecs[i].len));
                check("rd_data", i, 32'(rd_data), 32'(vecs[i].rdd));
            end
        end

        // Timeout: A5,04,01 then silence; error expected on the 32nd idle cycle.
        step(0, 1, 8'hA5, 0);
        step(0, 1, 8'h04, 0);
        step(0, 1, 8'h01, 0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 2 * TIMEOUT) begin
            step(0, 0, 8'h00, 0);
            n++;
            if (frame_error) seen = 1'b1;
        end
        check("tmo_cycles", 0, 32'(n), 32'(TIMEOUT));
        check("tmo_busy", 0, 32'(busy), 32'd0);
        step(0, 0, 8'h00, 0);
        check("tmo_err_width", 0, 32'(frame_error), 32'd0);
        step(0, 1, 8'h7E, 0);
        check("stray_busy", 0, 32'(busy), 32'd0);
        check("stray_err", 0, 32'(frame_error), 32'd0);

        // Accept on the terminal-count cycle must win over the timeout.
        step(0, 1, 8'hA5, 0);
        errs = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step(0, 0, 8'h00, 0);
            if (frame_error) errs++;
        end
        check("edge_early_err", 0, 32'(errs), 32'd0);
        step(0, 1, 8'h02, 0);
        check("edge_err", 0, 32'(frame_error), 32'd0);
        check("edge_busy", 0, 32'(busy), 32'd1);
        step(0, 1, 8'h10, 0);
        step(0, 1, 8'h20, 0);
        step(0, 1, 8'h32, 0);
        check("edge_ready", 0, 32'(frame_ready), 32'd1);
        check("edge_rd0", 0, 32'(rd_data), 32'h10);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        check("edge_drained", 0, 32'(busy), 32'd0);

        // Full-length frame 01..08; checksum 08^01^..^08 = 00.
        step(0, 1, 8'hA5, 0);
        step(0, 1, 8'h08, 0);
        for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 0);
        step(0, 1, 8'h00, 0);
        check("max_ready", 0, 32'(frame_ready), 32'd1);
        check("max_len", 0, 32'(frame_len), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("max_rd", i, 32'(rd_data), 32'(i + 1));
            step(0, 0, 8'h00, 1);
        end
        check("max_ready_end", 0, 32'(frame_ready), 32'd0);
        check("max_busy_end", 0, 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5: the frame start marker.
REQ-002 The block SHALL have parameter MAX_LEN, default 8: the maximum payload bytes per frame (buffer depth).
REQ-003 The block SHALL have parameter TIMEOUT, default 32: the maximum CLK_BPS cycles allowed between bytes inside a frame.
REQ-004 The block SHALL have port CLK_BPS, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port accept, input, 1 bit: one-cycle byte-received strobe from the UART receiver.
REQ-007 The block SHALL have port receive_data, input, 8 bits: received byte, valid only in the cycle accept=1.
REQ-008 The block SHALL have port rd_en, input, 1 bit: consumer pops one payload byte.
REQ-009 The block SHALL have port rd_data, output, 8 bits: the payload byte at the current read pointer.
REQ-010 The block SHALL have port frame_ready, output, 1 bit: a verified frame is held and readable.
REQ-011 The block SHALL have port frame_len, output, 4 bits: payload length of the held frame.
REQ-012 The block SHALL have port frame_error, output, 1 bit: one-cycle pulse on any frame rejection.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky flag; a byte arrived while a frame was held.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The block SHALL implement states IDLE, GET_LEN, PAYLOAD, CHECK and HOLD.
REQ-016 IDLE: accept with receive_data==SYNC_BYTE SHALL move to GET_LEN; any other byte SHALL be silently discarded.
REQ-017 GET_LEN: accept with byte value 1..MAX_LEN SHALL latch frame_len, seed the running checksum with that byte, and move to PAYLOAD.
REQ-018 GET_LEN: a length of 0 or greater than MAX_LEN SHALL pulse frame_error and return to IDLE.
REQ-019 PAYLOAD: each accept SHALL write the byte to buffer[wr_ptr], increment wr_ptr, and XOR the byte into the checksum; after frame_len bytes the block SHALL move to CHECK.
REQ-020 CHECK: on accept, a byte equal to the checksum SHALL move to HOLD with frame_ready=1 starting the next cycle; a mismatch SHALL pulse frame_error and return to IDLE.
REQ-021 HOLD: rd_data SHALL equal buffer[rd_ptr] combinationally; rd_en SHALL increment rd_ptr.
REQ-022 HOLD: rd_en on the byte at rd_ptr==frame_len-1 SHALL return the block to IDLE with frame_ready=0 the next cycle.
REQ-023 rd_en outside HOLD SHALL be ignored.
REQ-024 HOLD: any accept SHALL be dropped and SHALL set overrun; overrun SHALL clear only on reset.
REQ-025 In GET_LEN, PAYLOAD and CHECK, a timeout counter SHALL reset to 0 on each accept and otherwise increment; reaching TIMEOUT SHALL pulse frame_error and return to IDLE.
REQ-026 The timeout counter SHALL be held at 0 in IDLE and HOLD.
REQ-027 The checksum SHALL be 8-bit XOR with no carry; wr_ptr and rd_ptr SHALL be sized for MAX_LEN, cleared on entry to IDLE, and SHALL never wrap within a frame.
REQ-028 If accept and the timeout terminal count coincide in the same cycle, accept SHALL win and the counter SHALL clear.
REQ-029 frame_error SHALL be exactly one cycle wide per rejection; the block SHALL be able to accept SYNC_BYTE in the cycle immediately after returning to IDLE.

Reset
REQ-030 While reset=1, the block SHALL enter IDLE and clear wr_ptr, rd_ptr, checksum and the timeout counter.
REQ-031 While reset=1, the block SHALL drive rd_data=0, frame_ready=0, frame_len=0, frame_error=0, overrun=0 and busy=0.
REQ-032 Reset SHALL take priority over all inputs, including mid-frame and in HOLD; a partial frame SHALL be discarded with no frame_error pulse.

Verification
REQ-033 A bench SHALL check: bytes A5,03,11,22,33,03 -> frame_ready=1, frame_len=3; three rd_en pops -> 11,22,33, then IDLE and busy=0.
REQ-034 A bench SHALL check: A5,02,10,20 followed by checksum 00 (expected 32) -> frame_error single pulse, frame_ready stays 0, busy=0.
REQ-035 A bench SHALL check: A5,00 and A5,09 -> frame_error after each length byte; a subsequent valid frame is accepted.
REQ-036 A bench SHALL check: A5,04,01 then no accept for 32 cycles -> frame_error on timeout, IDLE; a stray 7E in IDLE -> no response.
REQ-037 A bench SHALL check: valid frame held, then an extra byte 55 sent before reading -> overrun=1, held data unchanged, overrun persists after the frame is drained.
REQ-038 A bench SHALL check: reset asserted after A5,03,11 -> all outputs 0, no frame_error; then A5,01,FF,FE -> frame_ready=1 with rd_data=FF.
